// File: rtl/ibuf_multi_if.sv
// Producer/backend-facing bundle of the compacting instruction buffer.
// master: fetch/decode side driving enqueue, flush and stall; slave: the buffer.
interface ibuf_multi_if #(
  parameter int ENQ_WIDTH = 4,
  parameter int DEQ_WIDTH = 4,
  parameter int DEPTH     = 16,
  parameter int DATA_W    = 64
);
  logic                          enq_valid;
  logic [ENQ_WIDTH-1:0]          enq_mask;
  logic [ENQ_WIDTH*DATA_W-1:0]   enq_data;
  logic                          full;
  logic                          flush;
  logic                          stall;
  logic [DEQ_WIDTH-1:0]          deq_valid;
  logic [DEQ_WIDTH*DATA_W-1:0]   deq_data;
  logic [$clog2(DEPTH):0]        count;

  modport master (
    output enq_valid, enq_mask, enq_data, flush, stall,
    input  full, deq_valid, deq_data, count
  );

  modport slave (
    input  enq_valid, enq_mask, enq_data, flush, stall,
    output full, deq_valid, deq_data, count
  );
endinterface

// File: rtl/ibuf_multi.sv
// Compacting multi-slot instruction buffer (circular queue) between predecode and decode.
// Optional same-cycle empty-buffer bypass to decode: define IBUF_BYPASS_EN.
module ibuf_multi #(
  parameter int ENQ_WIDTH = 4,
  parameter int DEQ_WIDTH = 4,
  parameter int DEPTH     = 16,
  parameter int DATA_W    = 64
) (
  input  logic        clk,
  input  logic        rst,
  ibuf_multi_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t DEQ_MAX  = cnt_t'(DEQ_WIDTH);
  localparam cnt_t FULL_THR = cnt_t'(DEPTH - ENQ_WIDTH);
  localparam cnt_t DEPTH_C  = cnt_t'(DEPTH);

  logic [DATA_W-1:0]    mem_q [DEPTH];
  ptr_t                 head_q, head_d, tail_q, tail_d;
  cnt_t                 count_q, count_d;
  logic                 full_q, full_d;
  logic                 accept, byp;
  cnt_t                 off [ENQ_WIDTH];
  cnt_t                 enq_pop, enq_n, deq_n, byp_n;
  logic [ENQ_WIDTH-1:0] wr_en;

  // Number of set mask bits strictly below slot n: the compacted position of slot n.
  function automatic cnt_t prefix_cnt(input logic [ENQ_WIDTH-1:0] m, input int n);
    cnt_t c;
    c = '0;
    for (int k = 0; k < ENQ_WIDTH; k++)
      if (k < n) c = c + cnt_t'(m[k]);
    return c;
  endfunction

  function automatic cnt_t sat_deq(input cnt_t n);
    return (n > DEQ_MAX) ? DEQ_MAX : n;
  endfunction

  always_comb begin
    accept  = bus.enq_valid && !full_q && !bus.flush;
    enq_pop = prefix_cnt(bus.enq_mask, ENQ_WIDTH);
    enq_n   = accept ? enq_pop : '0;
`ifdef IBUF_BYPASS_EN
    byp     = accept && (count_q == '0) && !bus.stall;
`else
    byp     = 1'b0;
`endif
    byp_n   = byp ? sat_deq(enq_pop) : '0;

    if (bus.flush || bus.stall) deq_n = '0;
    else if (byp)               deq_n = byp_n;
    else                        deq_n = sat_deq(count_q);

    // Bypassed slots skip storage; head==tail when empty, so head jumps over them.
    for (int i = 0; i < ENQ_WIDTH; i++) begin
      off[i]   = prefix_cnt(bus.enq_mask, i);
      wr_en[i] = accept && bus.enq_mask[i] && (off[i] >= byp_n);
    end

    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + ptr_t'(deq_n);
      tail_d  = tail_q + ptr_t'(enq_n);
      count_d = count_q + enq_n - deq_n;
    end
    full_d = count_d > FULL_THR;
  end

  always_comb begin
    bus.deq_valid = '0;
    bus.deq_data  = '0;
    for (int i = 0; i < DEQ_WIDTH; i++) begin
      bus.deq_data[i*DATA_W +: DATA_W] = mem_q[head_q + ptr_t'(i)];
      bus.deq_valid[i] = !bus.flush && !bus.stall && (cnt_t'(i) < count_q);
    end
`ifdef IBUF_BYPASS_EN
    for (int i = 0; i < DEQ_WIDTH; i++)
      for (int j = 0; j < ENQ_WIDTH; j++)
        if (byp && bus.enq_mask[j] && (off[j] == cnt_t'(i))) begin
          bus.deq_valid[i] = 1'b1;
          bus.deq_data[i*DATA_W +: DATA_W] = bus.enq_data[j*DATA_W +: DATA_W];
        end
`endif
  end

  assign bus.count = count_q;
  assign bus.full  = full_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < ENQ_WIDTH; i++)
      if (wr_en[i]) mem_q[tail_q + ptr_t'(off[i])] <= bus.enq_data[i*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  a_no_overflow:  assert property (@(posedge clk) disable iff (!rst) count_q <= DEPTH_C);
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst) deq_n <= count_q + enq_n);

endmodule

// File: tb/tb_ibuf_multi.sv
// Directed bench for ibuf_multi; adapts bypass-sensitive expectations to IBUF_BYPASS_EN.
module tb_ibuf_multi;
  localparam int EW = 4, DW = 4, D = 16, W = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  ibuf_multi_if #(.ENQ_WIDTH(EW), .DEQ_WIDTH(DW), .DEPTH(D), .DATA_W(W)) bus ();
  ibuf_multi    #(.ENQ_WIDTH(EW), .DEQ_WIDTH(DW), .DEPTH(D), .DATA_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [EW*W-1:0] pack4(input logic [63:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic logic [63:0] dslot(input int i);
    return bus.deq_data[i*W +: W];
  endfunction

  function automatic logic [63:0] v(input int k, input int s);
    return 64'h1000 + 64'(k * 16 + s);
  endfunction

  task automatic drive(input logic vld, input logic [EW-1:0] m, input logic [EW*W-1:0] d);
    bus.enq_valid = vld;
    bus.enq_mask  = m;
    bus.enq_data  = d;
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b0, '0, '0);
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_val("rst_count", 64'(bus.count), 64'd0);
    chk_val("rst_full",  64'(bus.full), 64'd0);
    chk_val("rst_dv",    64'(bus.deq_valid), 64'd0);
    rst = 1'b1;
    cyc;

    // Mask 1011 compacts A,B,D
    drive(1'b1, 4'b1011, pack4(64'hA, 64'hB, 64'hC, 64'hD));
    #1;
`ifdef IBUF_BYPASS_EN
    chk_val("t1_dv",  64'(bus.deq_valid), 64'h7);
    chk_val("t1_s0",  dslot(0), 64'hA);
    chk_val("t1_s1",  dslot(1), 64'hB);
    chk_val("t1_s2",  dslot(2), 64'hD);
    cyc;
    drive(1'b0, '0, '0);
    #1;
    chk_val("t1_cnt", 64'(bus.count), 64'd0);
    chk_val("t1_dv0", 64'(bus.deq_valid), 64'h0);
`else
    chk_val("t1_dv_same", 64'(bus.deq_valid), 64'h0);
    cyc;
    drive(1'b0, '0, '0);
    #1;
    chk_val("t1_cnt3", 64'(bus.count), 64'd3);
    chk_val("t1_dv",  64'(bus.deq_valid), 64'h7);
    chk_val("t1_s0",  dslot(0), 64'hA);
    chk_val("t1_s1",  dslot(1), 64'hB);
    chk_val("t1_s2",  dslot(2), 64'hD);
    cyc;
    chk_val("t1_cnt0", 64'(bus.count), 64'd0);
    chk_val("t1_dv0",  64'(bus.deq_valid), 64'h0);
`endif

    // Fill under stall up to full, reject fifth bundle, then drain in order
    bus.stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 4'hF, pack4(v(k, 0), v(k, 1), v(k, 2), v(k, 3)));
      cyc;
      if (k == 2) begin
        chk_val("t2_cnt12",  64'(bus.count), 64'd12);
        chk_val("t2_full12", 64'(bus.full), 64'd0);
      end
    end
    chk_val("t2_cnt16",  64'(bus.count), 64'd16);
    chk_val("t2_full16", 64'(bus.full), 64'd1);
    chk_val("t2_dv_stall", 64'(bus.deq_valid), 64'h0);
    drive(1'b1, 4'hF, pack4(64'hEE0, 64'hEE1, 64'hEE2, 64'hEE3));
    cyc;
    chk_val("t2_cnt_rej", 64'(bus.count), 64'd16);
    drive(1'b0, '0, '0);
    bus.stall = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk_val("t2_dv", 64'(bus.deq_valid), 64'hF);
      for (int s = 0; s < 4; s++) chk_val("t2_data", dslot(s), v(k, s));
      cyc;
      if (k == 0) begin
        chk_val("t2_cnt_d", 64'(bus.count), 64'd12);
        chk_val("t2_full_d", 64'(bus.full), 64'd0);
      end
    end
    chk_val("t2_cnt_end", 64'(bus.count), 64'd0);

    // Flush with count=9 and a same-cycle bundle
    bus.stall = 1'b1;
    drive(1'b1, 4'hF, pack4(v(5, 0), v(5, 1), v(5, 2), v(5, 3))); cyc;
    drive(1'b1, 4'hF, pack4(v(6, 0), v(6, 1), v(6, 2), v(6, 3))); cyc;
    drive(1'b1, 4'h1, pack4(v(7, 0), v(7, 1), v(7, 2), v(7, 3))); cyc;
    chk_val("t5_cnt9", 64'(bus.count), 64'd9);
    drive(1'b1, 4'hF, pack4(64'hF0, 64'hF1, 64'hF2, 64'hF3));
    bus.flush = 1'b1;
    bus.stall = 1'b0;
    #1;
    chk_val("t5_dv_fl", 64'(bus.deq_valid), 64'h0);
    cyc;
    bus.flush = 1'b0;
    drive(1'b0, '0, '0);
    #1;
    chk_val("t5_cnt",  64'(bus.count), 64'd0);
    chk_val("t5_full", 64'(bus.full), 64'd0);
    chk_val("t5_dv",   64'(bus.deq_valid), 64'h0);

    // Move head to 14, then enqueue across the wrap
    bus.stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, (k == 3) ? 4'b0011 : 4'hF, pack4(v(8, 0), v(8, 1), v(8, 2), v(8, 3)));
      cyc;
    end
    chk_val("t3_cnt14", 64'(bus.count), 64'd14);
    drive(1'b0, '0, '0);
    bus.stall = 1'b0;
    repeat (4) cyc;
    chk_val("t3_empty", 64'(bus.count), 64'd0);
    bus.stall = 1'b1;
    drive(1'b1, 4'hF, pack4(v(9, 0), v(9, 1), v(9, 2), v(9, 3)));
    cyc;
    drive(1'b0, '0, '0);
    bus.stall = 1'b0;
    #1;
    chk_val("t3_dv", 64'(bus.deq_valid), 64'hF);
    for (int s = 0; s < 4; s++) chk_val("t3_wrap", dslot(s), v(9, s));
    cyc;
    chk_val("t3_cnt0", 64'(bus.count), 64'd0);

    // Simultaneous enqueue and dequeue at count=5; zero-mask bundle has no effect
    bus.stall = 1'b1;
    drive(1'b1, 4'hF, pack4(v(10, 0), v(10, 1), v(10, 2), v(10, 3))); cyc;
    drive(1'b1, 4'h1, pack4(v(10, 4), 64'h0, 64'h0, 64'h0));          cyc;
    chk_val("t4_cnt5", 64'(bus.count), 64'd5);
    bus.stall = 1'b0;
    drive(1'b1, 4'hF, pack4(v(11, 0), v(11, 1), v(11, 2), v(11, 3)));
    #1;
    chk_val("t4_dv_a", 64'(bus.deq_valid), 64'hF);
    for (int s = 0; s < 4; s++) chk_val("t4_a", dslot(s), v(10, s));
    cyc;
    chk_val("t4_cnt_same", 64'(bus.count), 64'd5);
    drive(1'b1, 4'h0, pack4(64'hBAD0, 64'hBAD1, 64'hBAD2, 64'hBAD3));
    #1;
    chk_val("t4_dv_b", 64'(bus.deq_valid), 64'hF);
    chk_val("t4_b0", dslot(0), v(10, 4));
    chk_val("t4_b1", dslot(1), v(11, 0));
    chk_val("t4_b2", dslot(2), v(11, 1));
    chk_val("t4_b3", dslot(3), v(11, 2));
    cyc;
    chk_val("t4_cnt1", 64'(bus.count), 64'd1);
    drive(1'b0, '0, '0);
    #1;
    chk_val("t4_dv_c", 64'(bus.deq_valid), 64'h1);
    chk_val("t4_c0", dslot(0), v(11, 3));
    cyc;
    chk_val("t4_cnt0", 64'(bus.count), 64'd0);

    // Empty buffer, mask 0110: same cycle with bypass, else one cycle later
    drive(1'b1, 4'b0110, pack4(64'hC0, 64'hC1, 64'hC2, 64'hC3));
    #1;
`ifdef IBUF_BYPASS_EN
    chk_val("t6_dv",  64'(bus.deq_valid), 64'h3);
    chk_val("t6_s0",  dslot(0), 64'hC1);
    chk_val("t6_s1",  dslot(1), 64'hC2);
    cyc;
    drive(1'b0, '0, '0);
    #1;
    chk_val("t6_cnt", 64'(bus.count), 64'd0);
`else
    chk_val("t6_dv_same", 64'(bus.deq_valid), 64'h0);
    cyc;
    drive(1'b0, '0, '0);
    #1;
    chk_val("t6_cnt2", 64'(bus.count), 64'd2);
    chk_val("t6_dv",  64'(bus.deq_valid), 64'h3);
    chk_val("t6_s0",  dslot(0), 64'hC1);
    chk_val("t6_s1",  dslot(1), 64'hC2);
    cyc;
    chk_val("t6_cnt0", 64'(bus.count), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
